// File: rtl/grid_readout_pkg.sv
// Shared types and constants for the 8-neuron grid readout path.
package grid_readout_pkg;

  localparam int NEURONS = 8;
  localparam int SNAP_DW = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } frame_state_e;

  typedef logic [2:0] idx_t;

  typedef logic [SNAP_DW-1:0] snap_t [NEURONS];

  localparam idx_t LAST_IDX = 3'd7;

endpackage

// File: rtl/grid_readout_ser.sv
// Snapshot register, capture/overrun rule and valid/ready beat sequencer
// for the grid readout.
module grid_readout_ser
  import grid_readout_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  capture,
  input  logic                  settle_restart,
  input  logic [NEURONS*DW-1:0] cap_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW-1:0]         m_data,
  output logic [2:0]            m_idx,
  output logic                  m_last,
  output logic                  busy,
  output logic                  overrun
);

  // Stream handshake: a beat transfers on any posedge where m_valid & m_ready;
  // while m_valid is high and m_ready low, m_valid/m_data/m_idx/m_last hold,
  // and m_valid never depends combinationally on m_ready.

  logic [DW-1:0] snap_q [NEURONS];
  idx_t          next_idx;
  logic          hs;
  logic          final_hs;
  logic          accept;

  assign next_idx = m_idx + 3'd1;
  assign hs       = m_valid & m_ready;
  assign final_hs = hs && (m_idx == LAST_IDX);
  // A capture landing on the last handshake reloads without a bubble.
  assign accept   = capture && (!busy || final_hs);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NEURONS; k++) snap_q[k] <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_idx   <= '0;
      m_last  <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else if (clear) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_idx   <= '0;
      m_last  <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if ((capture && !accept) || settle_restart) overrun <= 1'b1;

      if (accept) begin
        for (int k = 0; k < NEURONS; k++) snap_q[k] <= cap_data[k*DW +: DW];
        m_valid <= 1'b1;
        busy    <= 1'b1;
        m_idx   <= '0;
        m_data  <= cap_data[DW-1:0];
        m_last  <= 1'b0;
      end else if (final_hs) begin
        m_valid <= 1'b0;
        busy    <= 1'b0;
        m_idx   <= '0;
        m_data  <= '0;
        m_last  <= 1'b0;
      end else if (hs) begin
        m_idx  <= next_idx;
        m_data <= snap_q[next_idx];
        m_last <= (next_idx == LAST_IDX);
      end
    end
  end

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst)
    (m_valid && !m_ready && !clear) |=> (m_valid && $stable(m_data) && $stable(m_idx)));

  a_last_on_idx7: assert property (@(posedge clk) disable iff (!rst)
    m_last == (m_valid && (m_idx == LAST_IDX)));

endmodule

// File: rtl/grid_8_readout.sv
// Frame collector for the 8-neuron grid: trig edge counting, settle FSM and
// snapshot serialisation. Define GRID_READOUT_RELU_EN to rectify captured values.
module grid_8_readout
  import grid_readout_pkg::*;
#(
  parameter int N_INPUTS      = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int DW            = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trig,
  input  logic          clear,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  input  logic [DW-1:0] din4,
  input  logic [DW-1:0] din5,
  input  logic [DW-1:0] din6,
  input  logic [DW-1:0] din7,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [2:0]    m_idx,
  output logic          m_last,
  output logic          busy,
  output logic          overrun,
  output logic          dbg_frame_state
);

  localparam int TCW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int SCW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [TCW-1:0] TRIG_LAST   = TCW'(N_INPUTS - 1);
  localparam logic [SCW-1:0] SETTLE_INIT = SCW'(SETTLE_CYCLES);

  logic                  trig_q;
  logic [TCW-1:0]        trig_cnt;
  logic [SCW-1:0]        settle_cnt;
  frame_state_e          state;
  logic                  trig_edge;
  logic                  frame_end;
  logic                  capture;
  logic                  settle_restart;
  logic [NEURONS*DW-1:0] cap_data;

  assign trig_edge      = trig & ~trig_q;
  assign frame_end      = trig_edge && (trig_cnt == TRIG_LAST);
  // A frame ending during settle restarts it instead of capturing.
  assign capture        = (state == SETTLE) && (settle_cnt == '0) && !frame_end && !clear;
  assign settle_restart = (state == SETTLE) && frame_end && !clear;
  assign dbg_frame_state = (state == SETTLE);

  // clear deliberately leaves trig_q alone so a held trig is not a new edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) trig_q <= 1'b0;
    else      trig_q <= trig;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      trig_cnt   <= '0;
      settle_cnt <= '0;
    end else if (clear) begin
      state      <= IDLE;
      trig_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      if (trig_edge) trig_cnt <= frame_end ? '0 : trig_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (frame_end) begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_INIT;
          end
        end
        SETTLE: begin
          if (frame_end)              settle_cnt <= SETTLE_INIT;
          else if (settle_cnt == '0)  state      <= IDLE;
          else                        settle_cnt <= settle_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cap_data = {din7, din6, din5, din4, din3, din2, din1, din0};
`ifdef GRID_READOUT_RELU_EN
    for (int k = 0; k < NEURONS; k++) begin
      if (cap_data[k*DW + DW - 1]) cap_data[k*DW +: DW] = '0;
    end
`else
`endif
  end

  grid_readout_ser #(
    .DW (DW)
  ) u_ser (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .capture        (capture),
    .settle_restart (settle_restart),
    .cap_data       (cap_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_idx          (m_idx),
    .m_last         (m_last),
    .busy           (busy),
    .overrun        (overrun)
  );

endmodule

// File: tb/tb_grid_8_readout.sv
// Directed bench for grid_8_readout with N_INPUTS=4, SETTLE_CYCLES=4.
module tb_grid_8_readout;

  localparam int N_IN   = 4;
  localparam int SETTLE = 4;
  localparam int DW     = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          trig = 1'b0;
  logic          clear = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] din [8];
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [2:0]    m_idx;
  logic          m_last;
  logic          busy;
  logic          overrun;
  logic          dbg_frame_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  grid_8_readout #(
    .N_INPUTS      (N_IN),
    .SETTLE_CYCLES (SETTLE),
    .DW            (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .trig            (trig),
    .clear           (clear),
    .din0            (din[0]),
    .din1            (din[1]),
    .din2            (din[2]),
    .din3            (din[3]),
    .din4            (din[4]),
    .din5            (din[5]),
    .din6            (din[6]),
    .din7            (din[7]),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_idx           (m_idx),
    .m_last          (m_last),
    .busy            (busy),
    .overrun         (overrun),
    .dbg_frame_state (dbg_frame_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] stored(input logic [7:0] v);
`ifdef GRID_READOUT_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  // driver tasks
  task automatic set_din(input logic [63:0] v);
    for (int k = 0; k < 8; k++) din[k] = v[k*8 +: 8];
  endtask

  task automatic push_frame(input logic [63:0] v);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      b = v[k*8 +: 8];
      exp_q.push_back({(k == 7), 3'(k), stored(b)});
    end
  endtask

  task automatic send_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) trig = 1'b1;
      @(negedge clk) trig = 1'b0;
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!m_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    if (!m_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic idle_count_valid(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
  endtask

  // scoreboard: pops exp_q on every handshake
  task automatic collect(input int n, input int stall_idx, input int stall_len,
                         input logic [31:0] trig_pat, output int cyc);
    int          got;
    int          stalled;
    logic [11:0] e;
    got = 0;
    stalled = 0;
    cyc = 0;
    while (got < n && cyc < 200) begin
      trig = (cyc < 32) ? trig_pat[cyc] : 1'b0;
      m_ready = 1'b1;
      if (m_valid && m_idx == 3'(stall_idx) && stalled < stall_len) begin
        m_ready = 1'b0;
        stalled++;
        if (exp_q.size() > 0) check("stall_hold", {m_last, m_idx, m_data}, exp_q[0]);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat", {m_last, m_idx, m_data}, e);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    trig = 1'b0;
    check("beat_count", got, n);
  endtask

  initial begin
    int w;
    int c;
    int seen;
    set_din(64'h0);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_idx", m_idx, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    // frame and full-rate drain
    set_din(64'h0807060504030201);
    m_ready = 1'b1;
    send_edges(4);
    wait_valid(w);
    check("first_valid_latency", 1 + w, SETTLE + 2);
    push_frame(64'h0807060504030201);
    collect(8, 0, 0, 32'h0, c);
    check("drain_cycles", c, 8);
    check("drained_valid", m_valid, 0);
    check("drained_busy", busy, 0);
    check("drained_overrun", overrun, 0);

    // backpressure at idx 3 for 10 cycles
    set_din(64'h7060504030201000);
    send_edges(4);
    wait_valid(w);
    push_frame(64'h7060504030201000);
    collect(8, 3, 10, 32'h0, c);
    check("stall_drain_cycles", c, 18);

    // second frame dropped while busy
    set_din(64'h1122334455667718);
    send_edges(4);
    wait_valid(w);
    m_ready = 1'b0;
    set_din(64'h6655443322110F0E);
    send_edges(4);
    repeat (8) @(negedge clk);
    check("drop_overrun", overrun, 1);
    check("drop_busy", busy, 1);
    check("drop_idx", m_idx, 0);
    check("drop_data_kept", m_data, 8'h18);
    push_frame(64'h1122334455667718);
    collect(8, 0, 0, 32'h0, c);
    check("overrun_sticky", overrun, 1);
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    check("clear_overrun", overrun, 0);

    // capture coincident with idx-7 handshake
    set_din(64'h0102030405060708);
    send_edges(4);
    send_edges(2);
    wait_valid(w);
    set_din(64'h0F1E2D3C4B5A6978);
    push_frame(64'h0102030405060708);
    push_frame(64'h0F1E2D3C4B5A6978);
    collect(16, 0, 0, 32'b101, c);
    check("b2b_cycles", c, 16);
    check("b2b_overrun", overrun, 0);
    check("b2b_done_valid", m_valid, 0);

    // rectification of negative inputs
    set_din(64'h807F030201FF05F0);
    send_edges(4);
    wait_valid(w);
`ifdef GRID_READOUT_RELU_EN
    check("relu_din0", m_data, 8'h00);
`else
    check("relu_din0", m_data, 8'hF0);
`endif
    push_frame(64'h807F030201FF05F0);
    collect(8, 0, 0, 32'h0, c);

    // clear during settle
    m_ready = 1'b0;
    set_din(64'h0101010101010101);
    send_edges(4);
    wait_valid(w);
    send_edges(4);
    repeat (6) @(negedge clk);
    check("pre_clear_overrun", overrun, 1);
    send_edges(4);
    check("in_settle", dbg_frame_state, 1);
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    check("clear_settle_overrun", overrun, 0);
    check("clear_settle_valid", m_valid, 0);
    check("clear_settle_busy", busy, 0);
    m_ready = 1'b1;
    idle_count_valid(12, seen);
    check("no_capture_after_clear", seen, 0);

    // reset mid-send
    set_din(64'h2222222222222222);
    send_edges(4);
    wait_valid(w);
    w = 0;
    while (m_idx != 3'd2 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("reached_idx2", m_idx, 2);
    rst = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_m_idx", m_idx, 0);
    check("midrst_m_last", m_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    @(negedge clk) rst = 1'b1;
    idle_count_valid(20, seen);
    check("no_beats_after_rst", seen, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
